// File: rtl/rx_prbs_checker_if.sv
// Bit-stream and status bundle between the receive slicer and the PRBS checker.
// Carries one bit per clk; no handshake, the checker always accepts the bit.
interface rx_prbs_checker_if #(
    parameter int CNT_WIDTH = 32
) ();
    logic                 en;
    logic                 clr;
    logic                 data_i;
    logic                 locked;
    logic                 err_o;
    logic [CNT_WIDTH-1:0] bit_count;
    logic [CNT_WIDTH-1:0] err_count;
    logic [1:0]           state_o;

    modport master (
        output en, clr, data_i,
        input  locked, err_o, bit_count, err_count, state_o
    );

    modport slave (
        input  en, clr, data_i,
        output locked, err_o, bit_count, err_count, state_o
    );
endinterface

// File: rtl/rx_prbs_checker.sv
// Self-synchronizing PRBS checker: seeds, acquires, locks, then counts bits and errors.
// Latency: err_o and counters update 1 cycle after the bit is sampled; no backpressure.
module rx_prbs_checker #(
    parameter int PRBS_ORDER  = 7,
    parameter int CNT_WIDTH   = 32,
    parameter int LOCK_THRESH = 32,
    parameter int LOSS_WIN    = 256,
    parameter int LOSS_THRESH = 8
) (
    input  logic               clk,
    input  logic               rst,
    rx_prbs_checker_if.slave   bus
);
    localparam int TAP_B  = (PRBS_ORDER == 7)  ? 6  :
                            (PRBS_ORDER == 9)  ? 5  :
                            (PRBS_ORDER == 15) ? 14 :
                            (PRBS_ORDER == 23) ? 18 :
                            (PRBS_ORDER == 31) ? 28 : 0;
    localparam int SEED_W = $clog2(PRBS_ORDER);
    localparam int RUN_W  = $clog2(LOCK_THRESH + 1);
    localparam int WIN_W  = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
    localparam int WERR_W = $clog2(LOSS_THRESH + 1);

    generate
        if (TAP_B == 0) begin : g_bad_order
            $error("PRBS_ORDER must be one of 7, 9, 15, 23, 31");
        end
        if (LOCK_THRESH < 1 || LOSS_THRESH < 1 || LOSS_THRESH > LOSS_WIN) begin : g_bad_thresh
            $error("LOCK_THRESH >= 1 and 1 <= LOSS_THRESH <= LOSS_WIN required");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEED   = 2'd1,
        ST_ACQ    = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [PRBS_ORDER-1:0] sr_q, sr_d;
    logic [SEED_W-1:0]     seed_cnt_q, seed_cnt_d;
    logic [RUN_W-1:0]      run_cnt_q, run_cnt_d;
    logic [WIN_W-1:0]      win_cnt_q, win_cnt_d;
    logic [WERR_W-1:0]     win_err_q, win_err_d;
    logic [CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
    logic                  err_q, err_d;

    logic data_i;
    logic pred;
    logic mismatch;
    logic win_last;

    assign data_i   = bus.data_i;
    assign pred     = sr_q[PRBS_ORDER-1] ^ sr_q[TAP_B-1];
    assign mismatch = data_i ^ pred;
    assign win_last = (win_cnt_q == WIN_W'(LOSS_WIN - 1));

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        seed_cnt_d = seed_cnt_q;
        run_cnt_d  = run_cnt_q;
        win_cnt_d  = win_cnt_q;
        win_err_d  = win_err_q;
        bit_cnt_d  = bit_cnt_q;
        err_cnt_d  = err_cnt_q;
        err_d      = 1'b0;

        if (!bus.en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_SEED;
                    seed_cnt_d = '0;
                end
                ST_SEED: begin
                    sr_d = {sr_q[PRBS_ORDER-2:0], data_i};
                    if (seed_cnt_q == SEED_W'(PRBS_ORDER - 1)) begin
                        state_d   = ST_ACQ;
                        run_cnt_d = '0;
                    end else begin
                        seed_cnt_d = seed_cnt_q + SEED_W'(1);
                    end
                end
                ST_ACQ: begin
                    sr_d = {sr_q[PRBS_ORDER-2:0], data_i};
                    // An all-zero register predicts zeros forever; never count it as a match.
                    if (!mismatch && (sr_q != '0)) begin
                        run_cnt_d = run_cnt_q + RUN_W'(1);
                        if (run_cnt_q == RUN_W'(LOCK_THRESH - 1)) begin
                            state_d   = ST_LOCKED;
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end
                    end else begin
                        run_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    sr_d = {sr_q[PRBS_ORDER-2:0], pred};
                    if (bit_cnt_q != {CNT_WIDTH{1'b1}})
                        bit_cnt_d = bit_cnt_q + CNT_WIDTH'(1);
                    win_cnt_d = win_last ? '0 : win_cnt_q + WIN_W'(1);
                    win_err_d = win_last ? '0 : win_err_q + WERR_W'(mismatch);
                    if (mismatch) begin
                        err_d = 1'b1;
                        if (err_cnt_q != {CNT_WIDTH{1'b1}})
                            err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
                        if (win_err_q == WERR_W'(LOSS_THRESH - 1)) begin
                            state_d    = ST_SEED;
                            seed_cnt_d = '0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (bus.clr) begin
            bit_cnt_d = '0;
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sr_q       <= '0;
            seed_cnt_q <= '0;
            run_cnt_q  <= '0;
            win_cnt_q  <= '0;
            win_err_q  <= '0;
            bit_cnt_q  <= '0;
            err_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            seed_cnt_q <= seed_cnt_d;
            run_cnt_q  <= run_cnt_d;
            win_cnt_q  <= win_cnt_d;
            win_err_q  <= win_err_d;
            bit_cnt_q  <= bit_cnt_d;
            err_cnt_q  <= err_cnt_d;
            err_q      <= err_d;
        end
    end

    assign bus.locked    = (state_q == ST_LOCKED);
    assign bus.err_o     = err_q;
    assign bus.bit_count = bit_cnt_q;
    assign bus.err_count = err_cnt_q;
    assign bus.state_o   = state_q;
endmodule

// File: doc/rx_prbs_checker.md
Name: rx_prbs_checker

Overview:
- Downstream consumer of the receiver's sliced bit stream (data_o, clocked by the recovered clk_o).
- Self-synchronizes a PRBS reference to the incoming bits, declares lock, then counts received bits and bit errors for BER measurement and link bring-up.
- Detects loss of lock and re-acquires automatically.
- Observability block; nothing in the data path depends on it.

Parameters:
- PRBS_ORDER, 7, polynomial order. Legal values and taps (feedback = sr[a-1] ^ sr[b-1]): 7:(7,6), 9:(9,5), 15:(15,14), 23:(23,18), 31:(31,28). Any other value is a compile-time error.
- CNT_WIDTH, 32, width of bit_count and err_count.
- LOCK_THRESH, 32, consecutive matches required to lock (>= 1).
- LOSS_WIN, 256, length in bits of the aligned loss-detection window.
- LOSS_THRESH, 8, errors within one window that declare loss of lock (>= 1, <= LOSS_WIN).

Ports:
- clk  input  1  recovered receiver clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  checker enable.
- clr  input  1  synchronous clear of bit_count and err_count.
- data_i  input  1  sliced receive bit, one per clk.
- locked  output  1  high while in LOCKED.
- err_o  output  1  registered one-cycle error pulse.
- bit_count  output  CNT_WIDTH  bits checked while locked.
- err_count  output  CNT_WIDTH  errors detected while locked.
- state_o  output  2  encoding: 0 IDLE, 1 SEED, 2 ACQ, 3 LOCKED.

Behaviour:
- Reset: clk single clock, rst asynchronous active-high. While rst is high, all outputs are 0, state = IDLE, the shift register sr (PRBS_ORDER bits) is 0, and all internal counters are 0.
- Shift register: sr[0] holds the newest bit. Predicted bit pred = sr[a-1] ^ sr[b-1]. Each sampled cycle shifts left, inserting either data_i or pred as specified per state.
- en = 0: from any state, next state is IDLE. Counters hold their values, err_o = 0.
- IDLE: when en = 1, go to SEED and clear seed_cnt.
- SEED: shift data_i into sr for exactly PRBS_ORDER cycles, then go to ACQ with run_cnt = 0. No comparisons are made.
- ACQ:
  - Each cycle, compare data_i with pred, then shift data_i into sr (self-synchronizing).
  - A match with sr != 0 increments run_cnt. A mismatch, or sr == 0, clears run_cnt. An all-zero sr can therefore never lock.
  - When run_cnt reaches LOCK_THRESH on a cycle, the next state is LOCKED and the window counters are cleared.
- LOCKED:
  - Shift pred into sr, so sr free-runs and errors do not propagate.
  - Each cycle, bit_count increments.
  - On data_i != pred: err_count increments, err_o = 1 on the next cycle, and win_err increments.
  - win_cnt counts 0..LOSS_WIN-1 and wraps. At wrap, win_err is cleared (aligned windows).
  - If win_err would reach LOSS_THRESH, the next state is SEED. The error that triggers loss is still counted. locked falls on the same edge.
- Latency:
  - err_o and the counter updates are visible 1 cycle after the bit is sampled.
  - locked rises on the edge that samples bit index PRBS_ORDER+LOCK_THRESH-1, counting from the first sampled bit in SEED as index 0.
- Counters: saturate at 2^CNT_WIDTH-1 and never wrap. err_count keeps counting independently if bit_count has saturated.
- clr: zeros both counters on the next edge in any state, without changing state or sr. If clr and an increment occur on the same cycle, clr wins and the result is 0.
- Reset mid-operation: everything returns immediately to reset values. Counts are lost.

Test Plan:
- Clean PRBS7, en = 1 at sample 0 with default parameters → locked = 1 after the edge sampling bit 38. state_o sequence 1→2→3. After a further 1000 bits: bit_count = 1000, err_count = 0, err_o never asserted.
- Locked on PRBS7, invert one bit at locked index 100 → exactly one err_o pulse on the following cycle, err_count = 1, locked stays 1, no further errors (free-running sr).
- Locked, inject 8 errors inside one aligned 256-bit window → locked drops on the 8th error, err_count = 8, state_o = 1. Clean stream continues → re-lock after 7+32 bits, counters resume from 8.
- 7 errors in window 0 and 7 errors in window 1 → no loss of lock, err_count = 14.
- data_i held at 0 for 500 cycles → state stays ACQ (2), locked = 0, counters 0. Also run with data_i toggling at random → never locks.
- CNT_WIDTH = 8, clean lock for 300 bits → bit_count saturates at 255. clr asserted together with an error → err_count = 0. rst asserted mid-LOCKED → all outputs 0 asynchronously, state_o = 0.
